// File: rtl/stripe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stripe_sequencer
// Purpose  : Walks an alignment stripe by stripe. For each stripe it fetches
//            64 packed B bases, streams A bases to the PE array from the
//            stripe's start offset, and collects the stripe result. After the
//            last stripe it gathers trace-back symbols and then signals done.
// Revision : 1.0 - initial release
// ============================================================================
module stripe_sequencer #(
  parameter int NUM_STRIPES = 16,
  parameter int SEQ_LEN     = 1024,
  parameter int TRACE_MAX   = 2048
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_go,
  output logic         o_busy,
  output logic         o_done,
  output logic [9:0]   o_a_addr,
  input  logic [1:0]   i_a_data,
  output logic [3:0]   o_b_addr,
  input  logic [127:0] i_b_data,
  output logic         o_pe_start,
  output logic [1:0]   o_pe_A,
  output logic [127:0] o_pe_B,
  input  logic         i_stripe_end,
  input  logic [9:0]   i_start_position,
  input  logic [9:0]   i_end_position,
  input  logic [13:0]  i_max_score,
  input  logic [1:0]   i_trace_dir,
  output logic         o_stripe_valid,
  output logic [3:0]   o_stripe_idx,
  output logic [10:0]  o_stripe_end_abs,
  output logic [13:0]  o_stripe_score,
  output logic         o_trace_valid,
  output logic [1:0]   o_trace_dir,
  output logic [10:0]  o_trace_idx
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_B     = 3'd1,
    S_GAP        = 3'd2,
    S_STREAM     = 3'd3,
    S_TRACE_WAIT = 3'd4,
    S_TRACE      = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  localparam logic [3:0]  c_last_stripe = 4'(NUM_STRIPES - 1);
  localparam logic [12:0] c_seq_len     = 13'(SEQ_LEN);
  localparam logic [10:0] c_trace_last  = 11'(TRACE_MAX - 1);
  localparam logic [11:0] c_j_max       = 12'hFFF;

  state_t         state_q, state_d;
  logic           load_phase_q, load_phase_d;  // 0: B address out, 1: B data back
  logic [3:0]     k_q, k_d;                    // current stripe index
  logic [9:0]     s_q, s_d;                    // stripe start offset in A
  logic [11:0]    j_q, j_d;                    // A address counter (saturating)
  logic [10:0]    cnt_q, cnt_d;                // trace symbol counter
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [3:0]     b_addr_q, b_addr_d;
  logic [127:0]   pe_b_q, pe_b_d;

  logic [11:0]    w_j_inc;
  logic [11:0]    w_jm1;

  assign w_j_inc = (j_q == c_j_max) ? j_q : j_q + 12'd1;

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_b_addr = b_addr_q;
  assign o_pe_B   = pe_b_q;

  // Next-state and next-register computation for the sequencing FSM
  always_comb begin
    state_d      = state_q;
    load_phase_d = load_phase_q;
    k_d          = k_q;
    s_d          = s_q;
    j_d          = j_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    b_addr_d     = 4'd0;
    pe_b_d       = pe_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_go) begin
          state_d      = S_LOAD_B;
          load_phase_d = 1'b0;
          k_d          = 4'd0;
          s_d          = 10'd0;
          cnt_d        = 11'd0;
          busy_d       = 1'b1;
          b_addr_d     = 4'd0;
        end
      end
      S_LOAD_B: begin
        if (!load_phase_q) begin
          load_phase_d = 1'b1;
        end else begin
          // Memory answered the address presented last cycle
          pe_b_d       = i_b_data;
          load_phase_d = 1'b0;
          j_d          = {2'b00, s_q};
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        j_d     = w_j_inc;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (i_stripe_end) begin
          s_d = s_q + i_start_position;
          if (k_q < c_last_stripe) begin
            k_d      = k_q + 4'd1;
            b_addr_d = k_q + 4'd1;
            state_d  = S_LOAD_B;
          end else begin
            state_d = S_TRACE_WAIT;
          end
        end else begin
          j_d = w_j_inc;
        end
      end
      S_TRACE_WAIT: begin
        // The marker that ended the last stripe must drop before tracing
        if (!i_stripe_end) begin
          state_d = S_TRACE;
          cnt_d   = 11'd0;
        end
      end
      S_TRACE: begin
        if (i_stripe_end || (cnt_q == c_trace_last)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      load_phase_q <= 1'b0;
      k_q          <= 4'd0;
      s_q          <= 10'd0;
      j_q          <= 12'd0;
      cnt_q        <= 11'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      b_addr_q     <= 4'd0;
      pe_b_q       <= 128'd0;
    end else begin
      state_q      <= state_d;
      load_phase_q <= load_phase_d;
      k_q          <= k_d;
      s_q          <= s_d;
      j_q          <= j_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      b_addr_q     <= b_addr_d;
      pe_b_q       <= pe_b_d;
    end
  end

  // Datapath outputs that follow the memory/PE handshake within the cycle
  always_comb begin
    o_a_addr         = 10'd0;
    o_pe_start       = 1'b0;
    o_pe_A           = 2'd0;
    o_stripe_valid   = 1'b0;
    o_stripe_idx     = 4'd0;
    o_stripe_end_abs = 11'd0;
    o_stripe_score   = 14'd0;
    o_trace_valid    = 1'b0;
    o_trace_dir      = 2'd0;
    o_trace_idx      = 11'd0;
    // A data on the bus this cycle belongs to the address issued for j-1
    w_jm1            = j_q - 12'd1;
    if (((state_q == S_GAP) || (state_q == S_STREAM)) && ({1'b0, j_q} < c_seq_len)) begin
      o_a_addr = j_q[9:0];
    end
    if (state_q == S_STREAM) begin
      if (i_stripe_end) begin
        o_stripe_valid   = 1'b1;
        o_stripe_idx     = k_q;
        o_stripe_end_abs = {1'b0, i_end_position} + {1'b0, s_q};
        o_stripe_score   = i_max_score;
      end else if ({1'b0, w_jm1} < c_seq_len) begin
        o_pe_start = 1'b1;
        o_pe_A     = i_a_data;
      end
    end
    if (state_q == S_TRACE) begin
      o_trace_valid = 1'b1;
      o_trace_dir   = i_trace_dir;
      o_trace_idx   = cnt_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stripe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stripe_sequencer
// Purpose  : Scoreboard bench for stripe_sequencer with A/B memory models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stripe_sequencer;

  localparam int NS   = 2;
  localparam int SEQ  = 1024;
  localparam int TMAX = 2048;

  logic         clk = 1'b0;
  logic         i_rst, i_go, i_stripe_end;
  logic [1:0]   a_data, i_trace_dir;
  logic [127:0] b_data;
  logic [9:0]   i_start_position, i_end_position;
  logic [13:0]  i_max_score;
  logic         o_busy, o_done, o_pe_start, o_stripe_valid, o_trace_valid;
  logic [9:0]   o_a_addr;
  logic [3:0]   o_b_addr, o_stripe_idx;
  logic [1:0]   o_pe_A, o_trace_dir;
  logic [127:0] o_pe_B;
  logic [10:0]  o_stripe_end_abs, o_trace_idx;
  logic [13:0]  o_stripe_score;

  always #5 clk = ~clk;

  stripe_sequencer #(.NUM_STRIPES(NS), .SEQ_LEN(SEQ), .TRACE_MAX(TMAX)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_go(i_go), .o_busy(o_busy), .o_done(o_done),
    .o_a_addr(o_a_addr), .i_a_data(a_data), .o_b_addr(o_b_addr), .i_b_data(b_data),
    .o_pe_start(o_pe_start), .o_pe_A(o_pe_A), .o_pe_B(o_pe_B),
    .i_stripe_end(i_stripe_end), .i_start_position(i_start_position),
    .i_end_position(i_end_position), .i_max_score(i_max_score), .i_trace_dir(i_trace_dir),
    .o_stripe_valid(o_stripe_valid), .o_stripe_idx(o_stripe_idx),
    .o_stripe_end_abs(o_stripe_end_abs), .o_stripe_score(o_stripe_score),
    .o_trace_valid(o_trace_valid), .o_trace_dir(o_trace_dir), .o_trace_idx(o_trace_idx)
  );

  // Memories with one-cycle read latency
  logic [1:0]   amem [SEQ];
  logic [127:0] bmem [16];
  always @(posedge clk) begin
    a_data <= amem[o_a_addr];
    b_data <= bmem[o_b_addr];
  end

  typedef struct packed { logic [1:0] a; logic [127:0] b; } beat_t;
  typedef struct packed { logic [3:0] idx; logic [10:0] end_abs; logic [13:0] score; } stripe_t;
  typedef struct packed { logic [10:0] idx; logic [1:0] dir; } trace_t;

  beat_t   beat_q[$];
  stripe_t stripe_q[$];
  trace_t  trace_q[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      exp_done = 0;
  bit      mon_en = 1'b0;

  int p_n[NS], p_end[NS], p_start[NS];
  int p_hold, p_trace;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Monitor: pop expectations whenever the DUT presents an output
  beat_t m_beat; stripe_t m_str; trace_t m_tr;
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_pe_start) begin
        if (beat_q.size() == 0) fail_msg("unexpected_pe_beat");
        else begin
          m_beat = beat_q.pop_front();
          chk("pe_A", o_pe_A, m_beat.a);
          chk("pe_B", o_pe_B, m_beat.b);
          chk("busy_stream", o_busy, 1);
        end
      end else if (o_pe_A !== 2'd0) chk("pe_A_idle_zero", o_pe_A, 0);
      if (o_stripe_valid) begin
        if (stripe_q.size() == 0) fail_msg("unexpected_stripe");
        else begin
          m_str = stripe_q.pop_front();
          chk("stripe_idx", o_stripe_idx, m_str.idx);
          chk("stripe_end_abs", o_stripe_end_abs, m_str.end_abs);
          chk("stripe_score", o_stripe_score, m_str.score);
        end
      end
      if (o_trace_valid) begin
        if (trace_q.size() == 0) fail_msg("unexpected_trace");
        else begin
          m_tr = trace_q.pop_front();
          chk("trace_idx", o_trace_idx, m_tr.idx);
          chk("trace_dir", o_trace_dir, m_tr.dir);
        end
      end
      if (o_done) begin
        if (exp_done == 0) fail_msg("unexpected_done");
        else begin
          exp_done--;
          chk("busy_at_done", o_busy, 0);
        end
      end
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_a_addr"}, o_a_addr, 0);
    chk({nm, "_b_addr"}, o_b_addr, 0);
    chk({nm, "_pe_start"}, o_pe_start, 0);
    chk({nm, "_pe_A"}, o_pe_A, 0);
    chk({nm, "_pe_B"}, o_pe_B, 0);
    chk({nm, "_stripe_valid"}, o_stripe_valid, 0);
    chk({nm, "_stripe_fields"}, {o_stripe_idx, o_stripe_end_abs, o_stripe_score}, 0);
    chk({nm, "_trace"}, {o_trace_valid, o_trace_dir, o_trace_idx}, 0);
  endtask

  // One full alignment from go pulse to done, driven from the p_* settings
  task automatic run_align();
    logic [9:0]  s;
    logic [13:0] sc;
    logic [1:0]  d;
    int          w;
    s = 10'd0;
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    for (int k = 0; k < NS; k++) begin
      w = 0;
      while (!o_pe_start && w < 10) begin @(posedge clk); #1; w++; end
      chk("gap_latency", w, 3);
      if (w >= 10) return;
      for (int c = 0; c < p_n[k]; c++) begin
        int idx;
        idx = int'(s) + c;
        if (idx < SEQ) beat_q.push_back({amem[idx], bmem[k]});
      end
      for (int c = 1; c <= p_n[k]; c++) begin
        @(posedge clk); #1;
        i_go = (c == 1 && p_n[k] > 1);
        if (c == p_n[k]) begin
          sc = 14'($urandom);
          i_stripe_end     = 1'b1;
          i_end_position   = 10'(p_end[k]);
          i_start_position = 10'(p_start[k]);
          i_max_score      = sc;
          stripe_q.push_back({4'(k), 11'(p_end[k]) + {1'b0, s}, sc});
          s = s + 10'(p_start[k]);
        end
      end
      @(posedge clk); #1;
      if (k == NS - 1) repeat (p_hold) begin @(posedge clk); #1; end
      i_stripe_end     = 1'b0;
      i_end_position   = 10'($urandom);
      i_start_position = 10'($urandom);
      i_max_score      = 14'($urandom);
    end
    w = 0;
    while (!o_trace_valid && w < 10) begin @(posedge clk); #1; w++; end
    chk("trace_latency", w, 1);
    if (w >= 10) return;
    for (int t = 0; t < TMAX; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      d = 2'($urandom);
      i_trace_dir = d;
      trace_q.push_back({11'(t), d});
      if (p_trace != 0 && t == p_trace - 1) begin
        i_stripe_end = 1'b1;
        break;
      end
    end
    exp_done++;
    @(posedge clk); #1;
    i_stripe_end = 1'b0;
    @(posedge clk); #1;
    chk("done_seen", exp_done, 0);
    chk("busy_after_done", o_busy, 0);
    chk("trace_queue_drained", trace_q.size(), 0);
    if (p_trace == 0) repeat (52) @(posedge clk);
    #1;
  endtask

  // Reset asserted in the middle of streaming, with go held alongside
  task automatic run_reset(input int m);
    int w;
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    w = 0;
    while (!o_pe_start && w < 10) begin @(posedge clk); #1; w++; end
    chk("rst_gap_latency", w, 3);
    for (int c = 0; c <= m; c++) beat_q.push_back({amem[c], bmem[0]});
    for (int c = 1; c <= m; c++) begin
      @(posedge clk); #1;
      i_go = c[0];
    end
    i_rst = 1'b1;
    i_go  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_go  = 1'b0;
    check_idle("mid_reset");
    chk("beats_flushed", beat_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset_busy", o_busy, 0);
    chk("idle_after_reset_b_addr", o_b_addr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_go = 1'b0; i_stripe_end = 1'b0; i_trace_dir = 2'd0;
    i_start_position = 10'd0; i_end_position = 10'd0; i_max_score = 14'd0;
    for (int i = 0; i < SEQ; i++) amem[i] = 2'($urandom);
    for (int i = 0; i < 16; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_idle");

    // Stripe 0 ends at 60 from S=0; stripe 1 runs from S=900 with end withheld
    p_n = '{70, 300}; p_end = '{60, 500}; p_start = '{900, 3};
    p_hold = 0; p_trace = 0;
    run_align();

    // Stripe 1 at S=1000 ending at 1000; trace cut short by the marker
    p_n = '{40, 90}; p_end = '{10, 1000}; p_start = '{1000, 7};
    p_hold = 3; p_trace = 25;
    run_align();

    run_reset(45);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NS; k++) begin
        p_n[k]     = int'($urandom_range(2, 200));
        p_end[k]   = int'($urandom_range(0, 1023));
        p_start[k] = int'($urandom_range(0, 1023));
      end
      p_hold  = int'($urandom_range(0, 3));
      p_trace = int'($urandom_range(1, 300));
      run_align();
    end

    chk("beat_queue_empty", beat_q.size(), 0);
    chk("stripe_queue_empty", stripe_q.size(), 0);
    chk("trace_queue_empty", trace_q.size(), 0);
    chk("done_pending", exp_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
